tree_cmd_front: RTL and testbench
=================================

# tree_cmd_front

Front-end command stage for the switch/button search-tree block. It synchronises and debounces the two push-buttons `k0` (find) and `k1` (insert) and captures the 4-bit switch key on each clean press. Each press becomes a one-entry command `{op, key}` in a 4-deep first-word-fall-through (FWFT) queue. The tree stage downstream consumes commands one at a time over a valid/ready handshake, so it never sees bounce, multi-cycle presses, or lost presses while it is busy searching.

## Interface
- `DEB_CYCLES`, default 50000: consecutive differing samples needed to accept a level change. The legal range is 2..65535, and the counter is 16 bits.
- `clk` in 1: system clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `k0` in 1: raw find button; active high.
- `k1` in 1: raw insert button; active high.
- `sw` in 4: raw key switches.
- `cmd_valid` out 1: queue head valid (= queue not empty).
- `cmd_op` out 1: head opcode; 0 = find, 1 = insert.
- `cmd_key` out 4: head key.
- `cmd_ready` in 1: consumer accepts head this cycle.
- `q_count` out 3: entries held, 0..4.
- `q_full` out 1: `q_count == 4`.
- `drop_cnt` out 4: presses discarded; saturates at 15.

## Operation
- **Input path.** `k0`, `k1` and `sw` pass through the input path (see Configuration) to give the samples `s0`, `s1` and `ssw`.
- **Debouncer, one per key.** Each key has a stable level `st` (reset 0) and a counter `cnt` (reset 0).
  - Sample equals `st`: `cnt` is set to 0.
  - Sample differs from `st` and `cnt < DEB_CYCLES-1`: `cnt` increments.
  - Sample differs from `st` and `cnt == DEB_CYCLES-1`: `st` flips and `cnt` is set to 0.
- **Press event.** A press is the edge where `st` flips 0→1. A release (1→0) generates nothing.
- **Key capture.** On a press edge, the key enqueued is `ssw` as sampled on that same edge.
- **Queue push.** One push per cycle.
  - Insert press: pushes `{1, ssw}`.
  - Find press: pushes `{0, ssw}`.
  - Both press edges in the same cycle: the insert is pushed; the find is dropped and `drop_cnt` increments.
- **Pop.** A pop occurs when `cmd_valid && cmd_ready`. `cmd_ready` while empty is ignored.
- **Full queue.** A push while full is accepted only if a pop happens in the same cycle. Otherwise it is dropped and `drop_cnt` increments.
- **Drop counter.** A double drop in one cycle (insert dropped due to full and find dropped) adds 2, saturating at 15.
- **Queue state.** Read and write pointers are 2 bits each and wrap 3→0.
  - Push only: `q_count` +1.
  - Pop only: `q_count` −1.
  - Push and pop together: `q_count` unchanged.
- **Head outputs.** `cmd_op` and `cmd_key` always present the head entry. When empty they hold the last head value and are don't-care.

## Timing
- **Reset values** (asynchronous, immediate on `rst`):
  - `cmd_valid`=0, `cmd_op`=0, `cmd_key`=0, `q_count`=0, `q_full`=0, `drop_cnt`=0.
  - All `st`=0, all `cnt`=0, pointers=0, synchroniser flops=0.
- **Reset mid-operation:** queue contents are lost and no partially-debounced press survives.
- **Key held through reset:** after reset the key debounces from `st`=0 and yields exactly one press.
- **Press latency**, from the first rising `clk` edge where the pin is high, with the pin held steady:
  - With `TREE_CMD_SYNC_EN`: `cmd_valid` rises after edge `2+DEB_CYCLES`.
  - Without `TREE_CMD_SYNC_EN`: `cmd_valid` rises after edge `DEB_CYCLES`.
- **Glitch rejection:** any pulse shorter than `DEB_CYCLES` samples produces no command.
- **Handshake:** the head is removed on the edge where `cmd_valid && cmd_ready`. The next entry is visible in the following cycle, so the downstream can sustain one pop per clock.
- **Push to visibility:** an entry pushed into an empty queue shows `cmd_valid`=1 the cycle after the push edge. Zero-cycle bypass is not allowed.

## Configuration
- **`TREE_CMD_SYNC_EN` defined:**
  - `k0`, `k1` and each bit of `sw` pass through a 2-flop synchroniser before the debouncer and key capture.
  - `ssw` is the synchronised value aligned with `s0`/`s1`.
- **`TREE_CMD_SYNC_EN` undefined:**
  - Inputs feed the debouncer and key capture directly; pins are assumed already synchronous to `clk`.
  - Latency is 2 cycles shorter; all other behaviour is identical.

## Test plan
All scenarios use `DEB_CYCLES=4` and `TREE_CMD_SYNC_EN` defined unless noted.

- **Clean insert:** `sw`=4'hA, `k1` held high 10 cycles, `cmd_ready`=0 → `cmd_valid` rises after edge 6 with `cmd_op`=1, `cmd_key`=4'hA, `q_count`=1; releasing `k1` adds nothing.
- **Bounce rejection:** `k0` toggles high 3 cycles / low 1 cycle ×5, then held high 4+ cycles → exactly one find command; `drop_cnt`=0.
- **Full queue:** `cmd_ready`=0 and 5 clean presses with keys 1, 2, 3, 4, 5 → `q_count`=4, `q_full`=1, `drop_cnt`=1. Popping four times yields keys 1, 2, 3, 4 in order.
- **Simultaneous keys:** `k0` and `k1` rise together, `sw`=4'h7 → one entry `{1, 7}`; `drop_cnt`=1.
- **Full with concurrent pop:** queue full, `cmd_ready`=1 on the press edge → push accepted, `q_count` stays 4, `drop_cnt` unchanged.
- **Reset mid-operation:** `rst` pulsed with 3 entries queued and `k1` mid-debounce → all outputs 0 immediately. `k1` still held after reset gives one insert after 6 further edges.

Source files
------------

// File: rtl/tree_cmd_front.sv
// tree_cmd_front: command front end for the switch/button search tree.
// Debounces the find (k0) and insert (k1) buttons, captures the 4-bit switch
// key on each clean press, and queues {op, key} commands in a 4-deep FWFT
// queue read by the tree stage over a valid/ready handshake.
//
// Optional feature macro: TREE_CMD_SYNC_EN
//   defined   -> k0, k1 and sw pass through a 2-flop synchroniser first
//   undefined -> pins are used directly (assumed synchronous to clk)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   k0         in   raw find button (active high)
//   k1         in   raw insert button (active high)
//   sw[3:0]    in   raw key switches
//   cmd_valid  out  queue head valid (queue not empty)
//   cmd_op     out  head opcode, 0 = find, 1 = insert
//   cmd_key    out  head key
//   cmd_ready  in   consumer accepts head this cycle
//   q_count    out  entries held, 0..4
//   q_full     out  q_count == 4
//   drop_cnt   out  discarded presses, saturating at 15
module tree_cmd_front #(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       k0,
  input  logic       k1,
  input  logic [3:0] sw,
  output logic       cmd_valid,
  output logic       cmd_op,
  output logic [3:0] cmd_key,
  input  logic       cmd_ready,
  output logic [2:0] q_count,
  output logic       q_full,
  output logic [3:0] drop_cnt
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned KEY_W  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_QW = 3;
  localparam int unsigned DROP_W = 4;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_QW-1:0] CNT_FULL  = CNT_QW'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_SAT  = '1;

  typedef struct packed {
    logic             op;
    logic [KEY_W-1:0] key;
  } cmd_t;

  // Samples seen by the debouncers and the key capture
  logic [1:0]       key_s;
  logic [KEY_W-1:0] sw_s;

`ifdef TREE_CMD_SYNC_EN
  // Two-flop synchroniser; sw travels with the buttons so the captured key
  // is aligned with the debouncer samples.
  logic [KEY_W+1:0] sync1_q;
  logic [KEY_W+1:0] sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sw, k1, k0};
      sync2_q <= sync1_q;
    end
  end

  assign key_s = sync2_q[1:0];
  assign sw_s  = sync2_q[KEY_W+1:2];
`else
  assign key_s = {k1, k0};
  assign sw_s  = sw;
`endif

  // One debouncer per button; press[g] pulses in the cycle whose edge flips
  // the stable level from 0 to 1, so the push happens on that same edge.
  logic [1:0] press;

  for (genvar g = 0; g < 2; g++) begin : g_deb
    logic             st_q;
    logic             st_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      if (key_s[g] == st_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        st_d  = ~st_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q  <= 1'b0;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    assign press[g] = st_d & ~st_q;
  end

  // Queue state
  cmd_t              mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_QW-1:0] count_q, count_d;
  logic              valid_q, valid_d;
  logic              full_q, full_d;
  cmd_t              head_q, head_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              pop;
  logic              push_req;
  logic              wr_en;
  logic              drop_both;
  logic              drop_full;
  cmd_t              push_cmd;
  logic [DROP_W:0]   drop_sum;

  // Push/pop arbitration, pointer/count update and head tracking
  always_comb begin
    pop       = valid_q & cmd_ready;
    push_req  = press[1] | press[0];
    push_cmd  = '{op: press[1], key: sw_s};
    drop_both = press[1] & press[0];
    wr_en     = push_req & (~full_q | pop);
    drop_full = push_req & full_q & ~pop;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    head_d    = head_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_QW'(1);
      2'b01:   count_d = count_q - CNT_QW'(1);
      default: count_d = count_q;
    endcase

    // The written entry is not in mem_q yet, so a push that becomes the new
    // head is forwarded into the head register directly.
    if (wr_en && ((count_q == '0) || ((count_q == CNT_QW'(1)) && pop))) begin
      head_d = push_cmd;
    end else if (pop && (count_q >= CNT_QW'(2))) begin
      head_d = mem_q[rd_ptr_d];
    end

    valid_d = (count_d != '0);
    full_d  = (count_d == CNT_FULL);

    drop_sum = (DROP_W+1)'(drop_q) + (DROP_W+1)'(drop_both) + (DROP_W+1)'(drop_full);
    drop_d   = (drop_sum > (DROP_W+1)'(DROP_SAT)) ? DROP_SAT : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      head_q   <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      head_q   <= head_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_cmd;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_op    = head_q.op;
  assign cmd_key   = head_q.key;
  assign q_count   = count_q;
  assign q_full    = full_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_tree_cmd_front.sv
// Testbench for tree_cmd_front (DEB_CYCLES = 4). Every cycle the DUT is
// compared with a behavioural model; table rows and hand sequences add
// directed expectations for the corner cases.
module tb_tree_cmd_front;

  localparam int unsigned DEB = 4;
`ifdef TREE_CMD_SYNC_EN
  localparam int unsigned SLAT = 2;
`else
  localparam int unsigned SLAT = 0;
`endif
  localparam int unsigned LAT = DEB + SLAT;

  logic       clk = 1'b0;
  logic       rst;
  logic       k0, k1;
  logic [3:0] sw;
  logic       cmd_ready;
  logic       cmd_valid, cmd_op;
  logic [3:0] cmd_key;
  logic [2:0] q_count;
  logic       q_full;
  logic [3:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  tree_cmd_front #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .k0(k0), .k1(k1), .sw(sw),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_key(cmd_key),
    .cmd_ready(cmd_ready), .q_count(q_count), .q_full(q_full),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // A level change is accepted once the last DEB samples all show the other
  // level; pins reach the debouncer SLAT edges late.
  bit [4:0]     mq[$];
  int           mdrop;
  bit           mst[2];
  bit [DEB-1:0] mhist[2];
  bit [5:0]     mdl[$];

  function automatic void model_reset();
    mq.delete();
    mdrop = 0;
    mst[0] = 1'b0; mst[1] = 1'b0;
    mhist[0] = '0; mhist[1] = '0;
    mdl.delete();
    for (int i = 0; i < int'(SLAT); i++) mdl.push_back(6'd0);
  endfunction

  function automatic void model_edge();
    bit [5:0] smp;
    bit       pr[2];
    bit       pop;
    bit       push;
    bit [4:0] c;
    mdl.push_back({sw, k1, k0});
    smp = mdl.pop_front();
    for (int i = 0; i < 2; i++) begin
      mhist[i] = {mhist[i][DEB-2:0], smp[i]};
      pr[i] = 1'b0;
      if (mhist[i] == {DEB{~mst[i]}}) begin
        mst[i] = ~mst[i];
        pr[i]  = mst[i];
      end
    end
    pop  = (mq.size() != 0) && cmd_ready;
    push = 1'b0;
    c    = '0;
    if (pr[1]) begin
      push = 1'b1;
      c = {1'b1, smp[5:2]};
      if (pr[0]) mdrop++;
    end else if (pr[0]) begin
      push = 1'b1;
      c = {1'b0, smp[5:2]};
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < 4) mq.push_back(c);
      else mdrop++;
    end
    if (mdrop > 15) mdrop = 15;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("m_valid", int'(cmd_valid), int'(mq.size() != 0));
    chk("m_count", int'(q_count), mq.size());
    chk("m_full", int'(q_full), int'(mq.size() == 4));
    chk("m_drop", int'(drop_cnt), mdrop);
    if (mq.size() != 0) begin
      chk("m_op", int'(cmd_op), int'(mq[0][4]));
      chk("m_key", int'(cmd_key), int'(mq[0][3:0]));
    end
  endtask

  // One clock: model steps on the edge, outputs checked on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_op", int'(cmd_op), 0);
    chk("rst_key", int'(cmd_key), 0);
    chk("rst_count", int'(q_count), 0);
    chk("rst_full", int'(q_full), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input bit op, input bit [3:0] key);
    sw = key;
    if (op) k1 = 1'b1; else k0 = 1'b1;
    repeat (8) cycle();
    k0 = 1'b0; k1 = 1'b0;
    repeat (8) cycle();
  endtask

  typedef struct {
    bit       k0, k1;
    bit [3:0] sw;
    bit       rdy;
    int       n;
    bit       ev;
    bit       eop;
    bit [3:0] ekey;
    int       ecnt;
    int       edrop;
    bit       chead;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{k0:0, k1:1, sw:4'hA, rdy:0, n:12, ev:1, eop:1, ekey:4'hA, ecnt:1, edrop:0, chead:1};
    tbl[1] = '{k0:0, k1:0, sw:4'h3, rdy:0, n:12, ev:1, eop:1, ekey:4'hA, ecnt:1, edrop:0, chead:1};
    tbl[2] = '{k0:0, k1:0, sw:4'h3, rdy:1, n:1,  ev:0, eop:0, ekey:4'h0, ecnt:0, edrop:0, chead:0};
    tbl[3] = '{k0:1, k1:0, sw:4'h5, rdy:0, n:12, ev:1, eop:0, ekey:4'h5, ecnt:1, edrop:0, chead:1};
    tbl[4] = '{k0:0, k1:0, sw:4'h0, rdy:0, n:12, ev:1, eop:0, ekey:4'h5, ecnt:1, edrop:0, chead:1};
    tbl[5] = '{k0:1, k1:1, sw:4'h7, rdy:0, n:12, ev:1, eop:0, ekey:4'h5, ecnt:2, edrop:1, chead:1};
    tbl[6] = '{k0:0, k1:0, sw:4'h0, rdy:1, n:1,  ev:1, eop:1, ekey:4'h7, ecnt:1, edrop:1, chead:1};
    tbl[7] = '{k0:0, k1:0, sw:4'h0, rdy:1, n:1,  ev:0, eop:0, ekey:4'h0, ecnt:0, edrop:1, chead:0};
    tbl[8] = '{k0:0, k1:0, sw:4'h0, rdy:1, n:12, ev:0, eop:0, ekey:4'h0, ecnt:0, edrop:1, chead:0};

    rst = 1'b1; k0 = 1'b0; k1 = 1'b0; sw = 4'h0; cmd_ready = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Table: clean insert, release, pop, find, simultaneous keys
    for (int i = 0; i < 9; i++) begin
      k0 = tbl[i].k0; k1 = tbl[i].k1; sw = tbl[i].sw; cmd_ready = tbl[i].rdy;
      repeat (tbl[i].n) cycle();
      chk($sformatf("row%0d_valid", i), int'(cmd_valid), int'(tbl[i].ev));
      chk($sformatf("row%0d_count", i), int'(q_count), tbl[i].ecnt);
      chk($sformatf("row%0d_drop", i), int'(drop_cnt), tbl[i].edrop);
      if (tbl[i].chead) begin
        chk($sformatf("row%0d_op", i), int'(cmd_op), int'(tbl[i].eop));
        chk($sformatf("row%0d_key", i), int'(cmd_key), int'(tbl[i].ekey));
      end
    end
    k0 = 0; k1 = 0; cmd_ready = 0;

    // Exact press latency
    do_reset();
    k1 = 1'b1; sw = 4'hC;
    for (int e = 1; e <= int'(LAT) + 2; e++) begin
      cycle();
      chk($sformatf("lat_valid_e%0d", e), int'(cmd_valid), int'(e >= int'(LAT)));
    end
    chk("lat_op", int'(cmd_op), 1);
    chk("lat_key", int'(cmd_key), 12);
    k1 = 1'b0;
    repeat (12) cycle();
    chk("lat_release_count", int'(q_count), 1);

    // Bounce rejection
    do_reset();
    sw = 4'h6;
    for (int b = 0; b < 5; b++) begin
      k0 = 1'b1; repeat (3) cycle();
      k0 = 1'b0; repeat (1) cycle();
    end
    chk("bounce_none", int'(q_count), 0);
    k0 = 1'b1; repeat (8) cycle();
    k0 = 1'b0; repeat (8) cycle();
    chk("bounce_count", int'(q_count), 1);
    chk("bounce_op", int'(cmd_op), 0);
    chk("bounce_key", int'(cmd_key), 6);
    chk("bounce_drop", int'(drop_cnt), 0);

    // Full queue, then drain in order
    do_reset();
    for (int i = 1; i <= 5; i++) press(1'b0, 4'(i));
    chk("full_count", int'(q_count), 4);
    chk("full_flag", int'(q_full), 1);
    chk("full_drop", int'(drop_cnt), 1);
    cmd_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("drain_key%0d", j), int'(cmd_key), j + 1);
      cycle();
    end
    chk("drain_empty", int'(cmd_valid), 0);
    cmd_ready = 1'b0;

    // Full queue with a pop on the press edge
    do_reset();
    for (int i = 1; i <= 4; i++) press(1'b1, 4'(i));
    k1 = 1'b1; sw = 4'h9;
    repeat (LAT - 1) cycle();
    cmd_ready = 1'b1;
    cycle();
    cmd_ready = 1'b0;
    chk("fpop_count", int'(q_count), 4);
    chk("fpop_drop", int'(drop_cnt), 0);
    chk("fpop_head", int'(cmd_key), 2);
    k1 = 1'b0;
    repeat (8) cycle();
    cmd_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("fpop_key%0d", j), int'(cmd_key), (j < 3) ? j + 2 : 9);
      cycle();
    end
    cmd_ready = 1'b0;

    // Reset mid-operation with k1 held through it
    do_reset();
    for (int i = 1; i <= 3; i++) press(1'b0, 4'(i));
    chk("mid_pre_count", int'(q_count), 3);
    k1 = 1'b1; sw = 4'hB;
    repeat (2) cycle();
    do_reset();
    for (int e = 1; e <= int'(LAT) + 1; e++) begin
      cycle();
      chk($sformatf("mid_valid_e%0d", e), int'(cmd_valid), int'(e >= int'(LAT)));
    end
    chk("mid_op", int'(cmd_op), 1);
    chk("mid_key", int'(cmd_key), 11);
    chk("mid_count", int'(q_count), 1);
    k1 = 1'b0;
    repeat (10) cycle();
    chk("mid_single", int'(q_count), 1);

    // Randomised traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) k0 = ~k0;
      if ($urandom_range(0, 5) == 0) k1 = ~k1;
      if ($urandom_range(0, 3) == 0) sw = 4'($urandom);
      cmd_ready = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1499) == 0) do_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
